// File: rtl/alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timekeeper
// Description : Time-of-day (hh:mm:ss, 24 h) and alarm core. Detects rising
//               edges of the debounced hour/minute/enable buttons, derives a
//               one-second tick from the input clock, keeps current time,
//               holds a settable alarm time and runs the arm/ring/disarm FSM.
// Ports       : clk         - only clock (5 MHz from the debouncer divider)
//               reset       - synchronous, active-high reset
//               hours_in    - debounced hour button (level, any length)
//               minutes_in  - debounced minute button (level, any length)
//               enable_in   - debounced alarm-enable button
//               set_alarm   - 1: buttons edit alarm time, 0: current time
//               cur_hour/cur_min/cur_sec - current time
//               alm_hour/alm_min         - alarm time
//               alarm_armed - high in ARMED or RINGING
//               alarm_ring  - high in RINGING
//               sec_tick    - one-cycle pulse per second boundary
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_timekeeper #(
    parameter int CLK_HZ      = 5000000,
    parameter int RING_SECS   = 60,
    parameter int ALARM_RST_H = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hours_in,
    input  logic       minutes_in,
    input  logic       enable_in,
    input  logic       set_alarm,
    output logic [4:0] cur_hour,
    output logic [5:0] cur_min,
    output logic [5:0] cur_sec,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic       alarm_armed,
    output logic       alarm_ring,
    output logic       sec_tick
);

    localparam int c_PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int c_RW = $clog2(RING_SECS + 1);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_HZ - 1);
    localparam logic [c_RW-1:0] c_RING_LAST = c_RW'(RING_SECS - 1);

    localparam logic [1:0] c_ST_DISARMED = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_RINGING  = 2'd2;

    // Button bit order in the edge-detect vectors: {enable, minute, hour}
    logic [2:0]      r_sync1_q, r_sync2_q;
    logic [2:0]      w_sync1_d;
    logic [2:0]      w_press;
    logic [c_PW-1:0] r_presc_q, w_presc_d;
    logic            r_tick_q, w_tick_d;
    logic [5:0]      r_sec_q, w_sec_d;
    logic [5:0]      r_min_q, w_min_d;
    logic [4:0]      r_hour_q, w_hour_d;
    logic [5:0]      r_alm_min_q, w_alm_min_d;
    logic [4:0]      r_alm_hour_q, w_alm_hour_d;
    logic [1:0]      r_state_q, w_state_d;
    logic [c_RW-1:0] r_ring_cnt_q, w_ring_cnt_d;
    logic            r_armed_q, w_armed_d;
    logic            r_ring_q, w_ring_d;
    logic            w_min_edit, w_hour_edit;
    logic            w_sec_carry, w_min_carry;
    logic            w_match;

    always_comb begin
        w_sync1_d = {enable_in, minutes_in, hours_in};
        w_press   = r_sync1_q & ~r_sync2_q;

        w_presc_d = (r_presc_q == c_PRESC_MAX) ? '0 : r_presc_q + c_PW'(1);
        // Registered so the pulse lines up with the cycle where the count is at max
        w_tick_d  = (w_presc_d == c_PRESC_MAX);

        w_min_edit  = w_press[1] & ~set_alarm;
        w_hour_edit = w_press[0] & ~set_alarm;

        w_sec_carry = r_tick_q && (r_sec_q == 6'd59);
        // A manual minute edit swallows the tick carry, so no hour carry follows it
        w_min_carry = w_sec_carry && !w_min_edit && (r_min_q == 6'd59);

        w_sec_d = r_sec_q;
        if (r_tick_q) begin
            w_sec_d = (r_sec_q == 6'd59) ? 6'd0 : r_sec_q + 6'd1;
        end

        // Press or carry (or both) advance the minute by exactly one
        w_min_d = r_min_q;
        if (w_min_edit || w_sec_carry) begin
            w_min_d = (r_min_q == 6'd59) ? 6'd0 : r_min_q + 6'd1;
        end

        w_hour_d = r_hour_q;
        if (w_hour_edit || w_min_carry) begin
            w_hour_d = (r_hour_q == 5'd23) ? 5'd0 : r_hour_q + 5'd1;
        end

        w_alm_min_d = r_alm_min_q;
        if (w_press[1] && set_alarm) begin
            w_alm_min_d = (r_alm_min_q == 6'd59) ? 6'd0 : r_alm_min_q + 6'd1;
        end

        w_alm_hour_d = r_alm_hour_q;
        if (w_press[0] && set_alarm) begin
            w_alm_hour_d = (r_alm_hour_q == 5'd23) ? 5'd0 : r_alm_hour_q + 5'd1;
        end

        w_match = r_tick_q && (w_hour_d == r_alm_hour_q) &&
                  (w_min_d == r_alm_min_q) && (w_sec_d == 6'd0);

        w_state_d    = r_state_q;
        w_ring_cnt_d = r_ring_cnt_q;
        case (r_state_q)
            c_ST_DISARMED: begin
                if (w_press[2]) w_state_d = c_ST_ARMED;
            end
            c_ST_ARMED: begin
                if (w_press[2]) begin
                    w_state_d = c_ST_DISARMED;
                end else if (w_match) begin
                    w_state_d    = c_ST_RINGING;
                    w_ring_cnt_d = '0;
                end
            end
            c_ST_RINGING: begin
                if (w_press[2]) begin
                    w_state_d = c_ST_DISARMED;
                end else if (r_tick_q) begin
                    if (r_ring_cnt_q == c_RING_LAST) begin
                        w_state_d = c_ST_ARMED;
                    end else begin
                        w_ring_cnt_d = r_ring_cnt_q + c_RW'(1);
                    end
                end
            end
            default: w_state_d = c_ST_DISARMED;
        endcase

        w_armed_d = (w_state_d != c_ST_DISARMED);
        w_ring_d  = (w_state_d == c_ST_RINGING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q    <= '0;
            r_sync2_q    <= '0;
            r_presc_q    <= '0;
            r_tick_q     <= 1'b0;
            r_sec_q      <= '0;
            r_min_q      <= '0;
            r_hour_q     <= '0;
            r_alm_min_q  <= '0;
            r_alm_hour_q <= 5'(ALARM_RST_H);
            r_state_q    <= c_ST_DISARMED;
            r_ring_cnt_q <= '0;
            r_armed_q    <= 1'b0;
            r_ring_q     <= 1'b0;
        end else begin
            r_sync1_q    <= w_sync1_d;
            r_sync2_q    <= r_sync1_q;
            r_presc_q    <= w_presc_d;
            r_tick_q     <= w_tick_d;
            r_sec_q      <= w_sec_d;
            r_min_q      <= w_min_d;
            r_hour_q     <= w_hour_d;
            r_alm_min_q  <= w_alm_min_d;
            r_alm_hour_q <= w_alm_hour_d;
            r_state_q    <= w_state_d;
            r_ring_cnt_q <= w_ring_cnt_d;
            r_armed_q    <= w_armed_d;
            r_ring_q     <= w_ring_d;
        end
    end

    assign cur_hour    = r_hour_q;
    assign cur_min     = r_min_q;
    assign cur_sec     = r_sec_q;
    assign alm_hour    = r_alm_hour_q;
    assign alm_min     = r_alm_min_q;
    assign alarm_armed = r_armed_q;
    assign alarm_ring  = r_ring_q;
    assign sec_tick    = r_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_timekeeper
// Description : Self-checking bench for alarm_timekeeper. A time-of-day model
//               (seconds since midnight) plus an alarm state model follows
//               every clock edge; all DUT outputs are compared each cycle, and
//               directed steps add fixed-value checks at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_timekeeper;

    localparam int CLK_HZ    = 10;
    localparam int RING_SECS = 5;
    localparam int ALM_RST_H = 7;
    localparam int DAY       = 86400;
    localparam int M_DIS     = 0;
    localparam int M_ARM     = 1;
    localparam int M_RING    = 2;

    logic       clk = 1'b0;
    logic       reset, hours_in, minutes_in, enable_in, set_alarm;
    logic [4:0] cur_hour, alm_hour;
    logic [5:0] cur_min, cur_sec, alm_min;
    logic       alarm_armed, alarm_ring, sec_tick;

    alarm_timekeeper #(
        .CLK_HZ     (CLK_HZ),
        .RING_SECS  (RING_SECS),
        .ALARM_RST_H(ALM_RST_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hours_in   (hours_in),
        .minutes_in (minutes_in),
        .enable_in  (enable_in),
        .set_alarm  (set_alarm),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alm_hour   (alm_hour),
        .alm_min    (alm_min),
        .alarm_armed(alarm_armed),
        .alarm_ring (alarm_ring),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    int       m_tod, m_ah, m_am, m_state, m_rcnt, m_cnt;
    bit       m_tick;
    bit [2:0] s1, s2;   // button levels seen at the last two edges {en,min,hr}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_tod();
        return int'(cur_hour) * 3600 + int'(cur_min) * 60 + int'(cur_sec);
    endfunction

    task automatic model_edge();
        int h, mi, s, t, nh, nm, ns;
        bit ph, pm, pe, match;
        if (reset) begin
            m_tod = 0; m_ah = ALM_RST_H; m_am = 0; m_state = M_DIS;
            m_rcnt = 0; m_cnt = 0; m_tick = 0; s1 = '0; s2 = '0;
            return;
        end
        ph = s1[0] & ~s2[0];
        pm = s1[1] & ~s2[1];
        pe = s1[2] & ~s2[2];
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        nh = h; nm = mi; ns = s;
        if (m_tick) begin
            t = (m_tod + 1) % DAY;
            nh = t / 3600; nm = (t / 60) % 60; ns = t % 60;
        end
        if (pm && !set_alarm) begin
            nm = (mi + 1) % 60;
            nh = h;
        end
        if (ph && !set_alarm) nh = (h + 1) % 24;
        match = m_tick && nh == m_ah && nm == m_am && ns == 0;
        if (set_alarm) begin
            if (pm) m_am = (m_am + 1) % 60;
            if (ph) m_ah = (m_ah + 1) % 24;
        end
        case (m_state)
            M_DIS: if (pe) m_state = M_ARM;
            M_ARM: begin
                if (pe) m_state = M_DIS;
                else if (match) begin m_state = M_RING; m_rcnt = 0; end
            end
            default: begin
                if (pe) m_state = M_DIS;
                else if (m_tick) begin
                    m_rcnt++;
                    if (m_rcnt == RING_SECS) m_state = M_ARM;
                end
            end
        endcase
        m_tod  = nh * 3600 + nm * 60 + ns;
        m_cnt  = (m_cnt + 1) % CLK_HZ;
        m_tick = (m_cnt == CLK_HZ - 1);
        s2 = s1;
        s1 = {enable_in, minutes_in, hours_in};
    endtask

    task automatic check_all();
        chk("cur_hour", cur_hour, m_tod / 3600);
        chk("cur_min", cur_min, (m_tod / 60) % 60);
        chk("cur_sec", cur_sec, m_tod % 60);
        chk("alm_hour", alm_hour, m_ah);
        chk("alm_min", alm_min, m_am);
        chk("alarm_armed", alarm_armed, m_state != M_DIS);
        chk("alarm_ring", alarm_ring, m_state == M_RING);
        chk("sec_tick", sec_tick, m_tick);
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hour"}, cur_hour, 0);
        chk({tag, "_min"}, cur_min, 0);
        chk({tag, "_sec"}, cur_sec, 0);
        chk({tag, "_alm_hour"}, alm_hour, ALM_RST_H);
        chk({tag, "_alm_min"}, alm_min, 0);
        chk({tag, "_armed"}, alarm_armed, 0);
        chk({tag, "_ring"}, alarm_ring, 0);
        chk({tag, "_tick"}, sec_tick, 0);
    endtask

    // which: 0 hour, 1 minute, 2 enable
    task automatic press(input int which);
        case (which)
            0: hours_in = 1'b1;
            1: minutes_in = 1'b1;
            default: enable_in = 1'b1;
        endcase
        cycle($urandom_range(3, 2));
        hours_in = 1'b0; minutes_in = 1'b0; enable_in = 1'b0;
        cycle($urandom_range(3, 2));
    endtask

    task automatic wait_tod(input int target, input int bound, input string tag);
        int k = 0;
        while (m_tod != target && k < bound) begin
            cycle();
            k++;
        end
        chk(tag, dut_tod(), target);
    endtask

    task automatic wait_sec0();
        int k = 0;
        while (m_tod % 60 != 0 && k < 700) begin
            cycle();
            k++;
        end
        chk("wait_sec0", cur_sec, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold, k;
        logic [4:0] save_h;
        logic in_set;
        reset = 1'b1; hours_in = 1'b0; minutes_in = 1'b0;
        enable_in = 1'b0; set_alarm = 1'b0;

        // Reset state
        cycle(3);
        check_reset_vals("reset");
        reset = 1'b0;

        // 60 ticks from reset
        cycle(600);
        chk("run60_min", cur_min, 1);
        chk("run60_sec", cur_sec, 0);
        chk("run60_alm_hour", alm_hour, 7);
        chk("run60_armed", alarm_armed, 0);

        // Long hold gives a single increment, two edges after the rise
        minutes_in = 1'b1;
        cycle(1);
        chk("press_lat1", cur_min, 1);
        cycle(1);
        chk("press_lat2", cur_min, 2);
        cycle(48);
        chk("press_hold", cur_min, 2);
        minutes_in = 1'b0;
        cycle(2);

        // Minute wraps 59 -> 0 without touching the hour
        while (m_tod / 60 % 60 != 59) press(1);
        save_h = 5'(m_tod / 3600);
        press(1);
        chk("min_wrap", cur_min, 0);
        chk("min_wrap_hour", cur_hour, save_h);

        // Preset 23:59:58 then cross midnight
        wait_sec0();
        while (m_tod / 3600 != 23) press(0);
        while ((m_tod / 60) % 60 != 59) press(1);
        wait_tod(23 * 3600 + 59 * 60 + 58, 700, "preset_2359");
        for (int i = 0; i < 20; i++) begin
            cycle();
            in_set = (dut_tod() == 86398) || (dut_tod() == 86399) || (dut_tod() == 0);
            chk("midnight_no_glitch", in_set, 1);
        end
        chk("midnight_hour", cur_hour, 0);
        chk("midnight_min", cur_min, 0);
        chk("midnight_sec", cur_sec, 0);

        // Minute press coincident with the seconds carry at 10:04:59
        while (m_tod / 3600 != 10) press(0);
        while ((m_tod / 60) % 60 != 4) press(1);
        k = 0;
        while (!(m_tod == 10 * 3600 + 4 * 60 + 59 && m_cnt == CLK_HZ - 2) && k < 800) begin
            cycle();
            k++;
        end
        chk("coinc_setup", dut_tod(), 10 * 3600 + 4 * 60 + 59);
        minutes_in = 1'b1;
        cycle(2);
        chk("coinc_hour", cur_hour, 10);
        chk("coinc_min", cur_min, 5);
        chk("coinc_sec", cur_sec, 0);
        minutes_in = 1'b0;
        cycle(2);

        // Alarm hour edit leaves current time alone
        set_alarm = 1'b1;
        press(0);
        press(0);
        chk("alm_edit_hour", alm_hour, 9);
        chk("alm_edit_cur_hour", cur_hour, 10);
        chk("alm_edit_cur_min", cur_min, 5);

        // Alarm at 00:02
        while (m_ah != 0) press(0);
        while (m_am != 2) press(1);
        set_alarm = 1'b0;
        wait_sec0();
        while (m_tod / 3600 != 0) press(0);
        while ((m_tod / 60) % 60 != 1) press(1);
        press(2);
        chk("arm", alarm_armed, 1);
        wait_tod(120, 800, "ring1_time");
        chk("ring1_on", alarm_ring, 1);
        cycle(RING_SECS * CLK_HZ - 1);
        chk("ring1_last", alarm_ring, 1);
        cycle(1);
        chk("ring1_off", alarm_ring, 0);
        chk("ring1_rearmed", alarm_armed, 1);

        // Enable press mid-ring disarms
        set_alarm = 1'b1;
        press(1);
        set_alarm = 1'b0;
        wait_tod(180, 800, "ring2_time");
        chk("ring2_on", alarm_ring, 1);
        cycle(10);
        enable_in = 1'b1;
        cycle(1);
        chk("ring2_press_n", alarm_ring, 1);
        cycle(1);
        chk("ring2_stop", alarm_ring, 0);
        chk("ring2_disarmed", alarm_armed, 0);
        enable_in = 1'b0;
        cycle(2);

        // Reset mid-ring with a button held through release
        press(2);
        set_alarm = 1'b1;
        press(1);
        set_alarm = 1'b0;
        wait_tod(240, 800, "ring3_time");
        chk("ring3_on", alarm_ring, 1);
        cycle(15);
        minutes_in = 1'b1;
        reset = 1'b1;
        cycle(2);
        check_reset_vals("midring_reset");
        reset = 1'b0;
        cycle(1);
        chk("held_rst_lat1", cur_min, 0);
        cycle(1);
        chk("held_rst_press", cur_min, 1);
        cycle(10);
        chk("held_rst_once", cur_min, 1);
        minutes_in = 1'b0;
        cycle(2);

        // Random button traffic against the model
        for (int i = 0; i < 150; i++) begin
            hours_in   = ($urandom_range(3, 0) == 0);
            minutes_in = ($urandom_range(3, 0) == 0);
            enable_in  = ($urandom_range(5, 0) == 0);
            set_alarm  = $urandom_range(1, 0) == 1;
            hold = $urandom_range(4, 1);
            cycle(hold);
        end
        hours_in = 1'b0; minutes_in = 1'b0; enable_in = 1'b0; set_alarm = 1'b0;
        cycle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
